// File: rtl/batch_ctrl.sv
`default_nettype none

// Shared encodings normally supplied by the main-FSM package; defaults kept
// here so the block stands on its own.
`ifndef MODE_LEN
`define MODE_LEN 2
`endif
`ifndef STATE_LEN
`define STATE_LEN 3
`endif
`ifndef M_IDLE
`define M_IDLE 3'd0
`endif
`ifndef M_FIN
`define M_FIN 3'd3
`endif
`ifndef TRAIN
`define TRAIN 2'd1
`endif

// ============================================================================
// Module      : batch_ctrl
// Description : Job sequencer ahead of state_main. It issues run and
//               next_batch for NUM_EPOCH x NUM_BATCH batches, tracks the
//               batch and epoch indices and reports busy/done.
//               Optional macro BATCH_CTRL_PAUSE_EN adds a pause input and a
//               HOLD state taken at non-final batch boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module batch_ctrl #(
    parameter int NUM_BATCH = 16,
    parameter int NUM_EPOCH = 4,
    parameter int CNT_LEN   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [`MODE_LEN-1:0]  mode_in,
    input  logic [`STATE_LEN-1:0] main_q,
`ifdef BATCH_CTRL_PAUSE_EN
    input  logic                  pause,
`endif
    output logic                  run,
    output logic                  next_batch,
    output logic [`MODE_LEN-1:0]  mode,
    output logic [CNT_LEN-1:0]    batch_idx,
    output logic [CNT_LEN-1:0]    epoch_idx,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] c_idle    = 3'd0;
    localparam logic [2:0] c_launch  = 3'd1;
    localparam logic [2:0] c_running = 3'd2;
    localparam logic [2:0] c_cont    = 3'd3;
    localparam logic [2:0] c_done    = 3'd4;
`ifdef BATCH_CTRL_PAUSE_EN
    localparam logic [2:0] c_hold    = 3'd5;
`endif

    localparam logic [CNT_LEN-1:0] c_last_batch = CNT_LEN'(NUM_BATCH - 1);
    localparam logic [CNT_LEN-1:0] c_last_epoch = CNT_LEN'(NUM_EPOCH - 1);
    localparam logic [CNT_LEN-1:0] c_one        = CNT_LEN'(1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [`STATE_LEN-1:0] r_main_prev;
    logic                  w_fin_entry;
    logic                  w_last_batch;
    logic                  w_accept;
    logic                  w_advance;
    logic                  w_run_nxt;
    logic                  w_next_batch_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    // A batch completes on the first cycle main_q shows M_FIN, however long it stays there.
    assign w_fin_entry  = (main_q == `M_FIN) && (r_main_prev != `M_FIN);
    assign w_last_batch = (batch_idx == c_last_batch) && (epoch_idx == c_last_epoch);
    assign w_accept     = ((r_state == c_idle) || (r_state == c_done)) && start;
    assign w_advance    = (r_state == c_running) && w_fin_entry && !w_last_batch;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle, c_done: begin
                if (start) begin
                    w_state_nxt = c_launch;
                end
            end
            c_launch: begin
                if (main_q != `M_IDLE) begin
                    w_state_nxt = c_running;
                end
            end
            c_running: begin
                if (w_fin_entry) begin
                    if (w_last_batch) begin
                        w_state_nxt = c_done;
                    end else begin
`ifdef BATCH_CTRL_PAUSE_EN
                        w_state_nxt = pause ? c_hold : c_cont;
`else
                        w_state_nxt = c_cont;
`endif
                    end
                end
            end
            c_cont: begin
                if (main_q != `M_FIN) begin
                    w_state_nxt = c_running;
                end
            end
`ifdef BATCH_CTRL_PAUSE_EN
            c_hold: begin
                if (!pause) begin
                    w_state_nxt = c_cont;
                end
            end
`endif
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs track it exactly.
    always_comb begin
        w_run_nxt        = (w_state_nxt == c_launch);
        w_next_batch_nxt = (w_state_nxt == c_cont);
        w_busy_nxt       = !((w_state_nxt == c_idle) || (w_state_nxt == c_done));
        w_done_nxt       = (w_state_nxt == c_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_prev <= `M_IDLE;
            run         <= 1'b0;
            next_batch  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mode        <= '0;
            batch_idx   <= '0;
            epoch_idx   <= '0;
        end else begin
            r_main_prev <= main_q;
            run         <= w_run_nxt;
            next_batch  <= w_next_batch_nxt;
            busy        <= w_busy_nxt;
            done        <= w_done_nxt;
            if (w_accept) begin
                mode      <= mode_in;
                batch_idx <= '0;
                epoch_idx <= '0;
            end else if (w_advance) begin
                if (batch_idx == c_last_batch) begin
                    batch_idx <= '0;
                    epoch_idx <= epoch_idx + c_one;
                end else begin
                    batch_idx <= batch_idx + c_one;
                end
            end
        end
    end

endmodule

`default_nettype wire
